// File: rtl/fft_frame_ctrl.sv
// fft_frame_ctrl: ping-pong frame buffer feeding a streaming 8-point FFT in cnt-aligned bursts,
// with a latency line that tags FFT output bins as valid/first/last/index.
module fft_frame_ctrl #(
    parameter int DBW      = 8,
    parameter int CBW      = 3,
    parameter int PIPE_LAT = 12
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             s_valid,
    input  logic [DBW-1:0]   s_data,
    output logic             s_ready,
    output logic             fft_clear,
    output logic [DBW-1:0]   fft_din,
    input  logic [2*DBW-1:0] fft_dout,
    output logic             m_valid,
    output logic [2*DBW-1:0] m_data,
    output logic             m_first,
    output logic             m_last,
    output logic [CBW-1:0]   m_index,
    output logic             busy
);
    localparam int N = 2 ** CBW;
    localparam logic [CBW-1:0] IDX_LAST = '1;

    typedef enum logic [1:0] {IDLE, CLR, RUN} state_t;
    state_t state_q, state_d;

    logic [DBW-1:0] mem_q [2][N];
    logic [1:0]     full_q, full_d;
    logic           wr_bank_q, rd_bank_q;
    logic [CBW-1:0] wr_idx_q, rd_idx_q;
    logic           fft_clear_q, fft_clear_d;
    logic [DBW-1:0] fft_din_q, fft_din_d;
    logic           tok_vld_q, tok_vld_d;
    logic [CBW-1:0] tok_idx_q, tok_idx_d;
    logic [PIPE_LAT-1:0] vld_q;
    logic [CBW-1:0] idx_q [PIPE_LAT];
    logic           wr_fire, wr_done, rd_last;

    assign s_ready = !full_q[wr_bank_q];
    assign wr_fire = s_valid && s_ready;
    assign wr_done = wr_fire && wr_idx_q == IDX_LAST;
    assign rd_last = state_q == RUN && rd_idx_q == IDX_LAST;

    // Writer and reader always own different banks, so both flag updates can land together.
    always_comb begin
        full_d = full_q;
        if (wr_done) full_d[wr_bank_q] = 1'b1;
        if (rd_last) full_d[rd_bank_q] = 1'b0;
    end

    always_comb begin
        state_d = state_q == IDLE ? (full_q[rd_bank_q] ? CLR : IDLE) :
                  state_q == CLR  ? RUN :
                  (rd_last && !full_d[!rd_bank_q]) ? IDLE : RUN;
    end

    // clear and din are both registered, so the FFT sees sample k exactly while its cnt==k.
    always_comb begin
        fft_clear_d = state_q == CLR;
        tok_vld_d   = state_q == RUN;
        tok_idx_d   = tok_vld_d ? rd_idx_q : '0;
        fft_din_d   = tok_vld_d ? mem_q[rd_bank_q][rd_idx_q] : '0;
    end

    always_ff @(posedge clk) begin
        if (wr_fire) mem_q[wr_bank_q][wr_idx_q] <= s_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            full_q      <= '0;
            wr_bank_q   <= 1'b0;
            rd_bank_q   <= 1'b0;
            wr_idx_q    <= '0;
            rd_idx_q    <= '0;
            fft_clear_q <= 1'b0;
            fft_din_q   <= '0;
            tok_vld_q   <= 1'b0;
            tok_idx_q   <= '0;
            vld_q       <= '0;
            for (int i = 0; i < PIPE_LAT; i++) idx_q[i] <= '0;
        end else begin
            state_q     <= state_d;
            full_q      <= full_d;
            if (wr_fire) wr_idx_q <= wr_idx_q + CBW'(1);
            if (wr_done) wr_bank_q <= !wr_bank_q;
            rd_idx_q    <= state_q == RUN ? rd_idx_q + CBW'(1) : '0;
            if (rd_last) rd_bank_q <= !rd_bank_q;
            fft_clear_q <= fft_clear_d;
            fft_din_q   <= fft_din_d;
            tok_vld_q   <= tok_vld_d;
            tok_idx_q   <= tok_idx_d;
            vld_q       <= {vld_q[PIPE_LAT-2:0], tok_vld_q};
            idx_q[0]    <= tok_idx_q;
            for (int i = 1; i < PIPE_LAT; i++) idx_q[i] <= idx_q[i-1];
        end
    end

    assign fft_clear = fft_clear_q;
    assign fft_din   = fft_din_q;
    assign m_valid   = vld_q[PIPE_LAT-1];
    assign m_index   = idx_q[PIPE_LAT-1];
    assign m_first   = m_valid && m_index == '0;
    assign m_last    = m_valid && m_index == IDX_LAST;
    assign m_data    = fft_dout;
    assign busy      = |full_q || state_q != IDLE || tok_vld_q || |vld_q;
endmodule
